// File: rtl/voice_command_decoder.sv
// rtl/voice_command_decoder.sv - wake-word armed keyword-to-command decoder
// Arms on WAKE_ID, maps the next command keyword inside the listen window, holds the code.
module voice_command_decoder #(
  parameter logic [7:0] WAKE_ID        = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         HOLD_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kw_valid,
  input  logic [7:0] kw_id,
  output logic       kw_ready,
  output logic [1:0] voice_command,
  output logic       cmd_strobe,
  output logic       listening,
  output logic       timeout_flag
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LISTEN, ISSUE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    cmd_d;
  logic          strobe_d, listening_d, tflag_d;
  logic          accept, is_wake, is_cmd;
  logic [1:0]    mapped;

  assign kw_ready = (state_q != ISSUE);
  assign accept   = kw_valid && kw_ready;
  assign is_wake  = (kw_id == WAKE_ID);

  // Wake word takes priority if WAKE_ID is ever parameterised onto a command ID.
  always_comb begin
    mapped = 2'b00;
    case (kw_id)
      8'h10:   mapped = 2'b01;
      8'h11:   mapped = 2'b10;
      8'h12:   mapped = 2'b11;
      default: mapped = 2'b00;
    endcase
  end
  assign is_cmd = !is_wake && (mapped != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      hold_q        <= '0;
      voice_command <= 2'b00;
      cmd_strobe    <= 1'b0;
      listening     <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      hold_q        <= hold_d;
      voice_command <= cmd_d;
      cmd_strobe    <= strobe_d;
      listening     <= listening_d;
      timeout_flag  <= tflag_d;
    end
  end

  // A command accepted while the timer reads 0 is checked before expiry, so it wins.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept && is_wake) begin
          state_d = LISTEN;
          timer_d = TW'(TIMEOUT_CYCLES - 1);
        end
      end
      LISTEN: begin
        if (accept && is_wake) begin
          timer_d = TW'(TIMEOUT_CYCLES - 1);
        end else if (accept && is_cmd) begin
          state_d = ISSUE;
          hold_d  = HW'(HOLD_CYCLES - 1);
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ISSUE: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - HW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d       = voice_command;
    strobe_d    = 1'b0;
    tflag_d     = 1'b0;
    listening_d = (state_d == LISTEN);
    if (state_q == LISTEN && state_d == ISSUE) begin
      cmd_d    = mapped;
      strobe_d = 1'b1;
    end
    if (state_q == LISTEN && state_d == IDLE) tflag_d = 1'b1;
    if (state_d == IDLE) cmd_d = 2'b00;
  end

endmodule

// File: tb/tb_voice_command_decoder.sv
// tb/tb_voice_command_decoder.sv - directed self-checking bench for voice_command_decoder
// Runs with TIMEOUT_CYCLES=8, HOLD_CYCLES=3.
module tb_voice_command_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kw_valid = 1'b0;
  logic [7:0] kw_id = 8'h00;
  logic       kw_ready;
  logic [1:0] voice_command;
  logic       cmd_strobe;
  logic       listening;
  logic       timeout_flag;

  int checks = 0;
  int errors = 0;
  int tf_cnt = 0;
  int acc_cnt = 0;

  voice_command_decoder #(
    .WAKE_ID(8'hA5),
    .TIMEOUT_CYCLES(8),
    .HOLD_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kw_valid(kw_valid),
    .kw_id(kw_id),
    .kw_ready(kw_ready),
    .voice_command(voice_command),
    .cmd_strobe(cmd_strobe),
    .listening(listening),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // Pulses and handshakes are stable for a whole cycle, so the falling edge sees each once.
  always @(negedge clk) begin
    if (timeout_flag) tf_cnt++;
    if (kw_valid && kw_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] id);
    kw_valid = 1'b1;
    kw_id    = id;
    tick();
    kw_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_listen;
    int tf0;
    int acc0;

    // reset state
    #2;
    check("rst_vc", voice_command, 2'b00);
    check("rst_listen", listening, 1'b0);
    check("rst_strobe", cmd_strobe, 1'b0);
    check("rst_tflag", timeout_flag, 1'b0);
    check("rst_ready", kw_ready, 1'b1);
    do_reset();

    // normal: A5, then 10 two cycles later
    send(8'hA5);
    check("n_listen", listening, 1'b1);
    tick();
    send(8'h10);
    check("n_strobe", cmd_strobe, 1'b1);
    check("n_vc0", voice_command, 2'b01);
    check("n_listen_off", listening, 1'b0);
    tick();
    check("n_strobe_off", cmd_strobe, 1'b0);
    check("n_vc1", voice_command, 2'b01);
    tick();
    check("n_vc2", voice_command, 2'b01);
    tick();
    check("n_vc_clr", voice_command, 2'b00);
    check("n_ready", kw_ready, 1'b1);

    // timeout: listening 8 cycles, one timeout pulse
    tf0 = tf_cnt;
    send(8'hA5);
    n_listen = 0;
    for (int i = 0; i < 20; i++) begin
      if (listening) n_listen++;
      tick();
    end
    check("to_len", n_listen, 8);
    check("to_pulses", tf_cnt - tf0, 1);
    check("to_vc", voice_command, 2'b00);

    // guarding
    send(8'h11);
    check("g_idle_listen", listening, 1'b0);
    check("g_idle_vc", voice_command, 2'b00);
    send(8'hA5);
    send(8'h7F);
    check("g_unknown_listen", listening, 1'b1);
    send(8'h11);
    for (int i = 0; i < 3; i++) begin
      check("g_vc", voice_command, 2'b10);
      check("g_ready_low", kw_ready, 1'b0);
      tick();
    end
    check("g_ready_back", kw_ready, 1'b1);
    check("g_vc_clr", voice_command, 2'b00);

    // window extend: A5 at 0, A5 at 6, 12 at 13
    tf0 = tf_cnt;
    send(8'hA5);
    repeat (5) tick();
    send(8'hA5);
    repeat (6) tick();
    check("w_still_listen", listening, 1'b1);
    send(8'h12);
    check("w_vc", voice_command, 2'b11);
    check("w_strobe", cmd_strobe, 1'b1);
    check("w_no_tflag", tf_cnt - tf0, 0);
    repeat (3) tick();

    // command on the timer==0 edge beats the timeout
    tf0 = tf_cnt;
    send(8'hA5);
    repeat (7) tick();
    check("b_listen", listening, 1'b1);
    send(8'h12);
    check("b_vc", voice_command, 2'b11);
    check("b_tflag", timeout_flag, 1'b0);
    repeat (3) tick();
    check("b_no_tflag", tf_cnt - tf0, 0);
    check("b_vc_clr", voice_command, 2'b00);

    // backpressure: 10 held through ISSUE, consumed once back in IDLE and dropped
    send(8'hA5);
    send(8'h10);
    acc0 = acc_cnt;
    kw_valid = 1'b1;
    kw_id    = 8'h10;
    tick();
    tick();
    check("bp_ready_low", kw_ready, 1'b0);
    check("bp_not_taken", acc_cnt - acc0, 0);
    tick();
    check("bp_ready_back", kw_ready, 1'b1);
    tick();
    kw_valid = 1'b0;
    check("bp_taken_once", acc_cnt - acc0, 1);
    check("bp_not_armed", listening, 1'b0);
    check("bp_vc", voice_command, 2'b00);

    // asynchronous reset mid-ISSUE
    tf0 = tf_cnt;
    send(8'hA5);
    send(8'h11);
    tick();
    check("r_pre_vc", voice_command, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    check("r_vc", voice_command, 2'b00);
    check("r_listen", listening, 1'b0);
    check("r_ready", kw_ready, 1'b1);
    #2;
    rst = 1'b0;
    repeat (3) tick();
    check("r_no_tflag", tf_cnt - tf0, 0);
    check("r_idle_vc", voice_command, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
